inst_mem_arbiter: RTL and testbench
===================================

Name: inst_mem_arbiter

Overview:
- Shares one instruction memory port between two requesters: ch0 is core instruction fetch; ch1 is a loader/debug master that initialises or patches instruction memory.
- Both requesters and the memory use a level req / single-cycle ack handshake.
- Fixed priority to ch0, with a starvation guard for ch1.
- Requests outside the memory window are rejected with an error and never reach memory.

Parameters:
- MEM_BASE, 32'h0, lowest byte address decoded to the memory (inclusive).
- MEM_END, 32'h0fff, highest byte address decoded to the memory (inclusive).
- MAX_WAIT, 4, consecutive ch0 grants allowed while ch1 waits before ch1 is forced ahead; range 1..15.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- ch0_req_i  in  1  core fetch request, held until ack
- ch0_addr_i  in  32  fetch address
- ch0_ack_o  out  1  fetch done, one cycle
- ch0_error_o  out  1  valid with ch0_ack_o
- ch0_rdata_o  out  32  fetch data, valid with ch0_ack_o
- ch1_req_i  in  1  loader request, held until ack
- ch1_we_i  in  1  1 = write
- ch1_be_i  in  4  byte enables for writes
- ch1_addr_i  in  32  loader address
- ch1_wdata_i  in  32  write data
- ch1_ack_o  out  1  loader transfer done, one cycle
- ch1_error_o  out  1  valid with ch1_ack_o
- ch1_rdata_o  out  32  read data, valid with ch1_ack_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_ack_i  in  1  memory done; may arrive in the request cycle or any later cycle
- mem_error_i  in  1  valid with mem_ack_i
- mem_rdata_i  in  32  valid with mem_ack_i

Behaviour:
- FSM states: IDLE, BUSY0, BUSY1, ERR0, ERR1. Reset state is IDLE.
- Reset values: every output is 0 and wait_cnt = 0.
- Address hit rule: MEM_BASE <= addr <= MEM_END, unsigned 32-bit compare.
- Arbitration in IDLE (combinational, same cycle):
  - Winner is ch1 if ch1_req_i and (not ch0_req_i or wait_cnt >= MAX_WAIT); otherwise ch0 if ch0_req_i; otherwise none.
- Winner address hits:
  - mem_* is driven from the winner in the same cycle (zero added latency).
  - If mem_ack_i arrives the same cycle: the winner's ack/error/rdata equal mem_ack_i/mem_error_i/mem_rdata_i combinationally, and the FSM stays in IDLE.
  - Otherwise the FSM goes to BUSYx.
- Winner address misses: mem_req_o stays 0, the FSM goes to ERRx, and the next cycle drives chx_ack_o = 1 and chx_error_o = 1 with chx_rdata_o = 0, then returns to IDLE.
- BUSYx:
  - Holds the grant. mem_* follows chx inputs; chx inputs must stay stable until ack.
  - The other channel's request is ignored.
  - On mem_ack_i, responses pass through combinationally to chx and the FSM returns to IDLE.
- Back-to-back: a new request is arbitrated in the cycle after an ack, so no bubble is forced beyond the IDLE re-evaluation.
- mem_we_o and mem_be_o:
  - Always 0 for a ch0 grant; ch0 is read-only.
  - mem_wdata_o = ch1_wdata_i when ch1 is granted, else 0.
- Non-granted channel outputs (ack, error, rdata) are 0.
- wait_cnt (4-bit, saturating at MAX_WAIT):
  - Increments on each ch0 ack while ch1_req_i = 1.
  - Clears to 0 on each ch1 ack, or whenever ch1_req_i = 0.
- ch0 address change without ack: illegal. Protocol-violation behaviour is undefined, except that no more than one mem transaction may ever be outstanding.
- Asynchronous reset mid-transaction: the FSM returns to IDLE and outputs go to 0 immediately. An in-flight mem ack after reset is ignored.

Optional Feature:
- Macro: INST_MEM_ARB_LOCK_EN.
- When defined:
  - Adds input ch1_lock_i (1 bit).
  - While ch1 holds a grant with ch1_lock_i = 1, the FSM stays dedicated to ch1 after each ack (LOCK1 substate). ch0 is never granted until ch1_lock_i = 0 in an IDLE/LOCK1 evaluation cycle.
  - Lets the loader perform atomic multi-word patches.
  - wait_cnt is held during the lock.
- When undefined: no port, no state. Arbitration is exactly as above.

Test Plan:
- Single fetch, zero-wait memory:
  - Stimulus: ch0_req = 1, addr = 0x100; mem acks the same cycle with rdata = 0xDEADBEEF.
  - Response: ch0_ack = 1 and rdata = 0xDEADBEEF in that cycle; mem_we = 0; FSM stays IDLE.
- Multi-cycle loader write:
  - Stimulus: ch1 write addr = 0x20, wdata = 0x12345678, be = 0xF; mem acks 3 cycles later.
  - Response: mem_req held for 4 cycles with stable fields; ch1_ack is one pulse; a ch0 request raised mid-transfer is not granted until the cycle after that ack.
- Out-of-range:
  - Stimulus: ch0 addr = 0x1000.
  - Response: mem_req never asserted; next cycle ch0_ack = 1, error = 1, rdata = 0.
- Starvation guard (MAX_WAIT = 4):
  - Stimulus: ch0 and ch1 both requesting continuously, zero-wait memory.
  - Response: grants follow ch0 ×4 then ch1 ×1, repeating; wait_cnt never exceeds 4.
- Simultaneous request with wait_cnt = 0: ch0 and ch1 raise req together -> ch0 granted first, ch1 on the next arbitration.
- Reset mid-transaction: rst_ni pulled low during BUSY1 -> all outputs 0 immediately; after release, a new ch0 fetch completes normally. With INST_MEM_ARB_LOCK_EN defined, also check that ch1_lock = 1 across 3 writes blocks ch0 until the lock drops.

Source files
------------

// File: rtl/inst_mem_arbiter.sv
// Instruction memory arbiter: fetch (ch0) has priority, loader (ch1) is starvation-guarded.
// Optional ch1 lock for atomic multi-word patches: define INST_MEM_ARB_LOCK_EN.
module inst_mem_arbiter #(
  parameter logic [31:0] MEM_BASE = 32'h0,
  parameter logic [31:0] MEM_END  = 32'h0fff,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ch0_req_i,
  input  logic [31:0] ch0_addr_i,
  output logic        ch0_ack_o,
  output logic        ch0_error_o,
  output logic [31:0] ch0_rdata_o,
  input  logic        ch1_req_i,
  input  logic        ch1_we_i,
  input  logic [3:0]  ch1_be_i,
  input  logic [31:0] ch1_addr_i,
  input  logic [31:0] ch1_wdata_i,
`ifdef INST_MEM_ARB_LOCK_EN
  input  logic        ch1_lock_i,
`endif
  output logic        ch1_ack_o,
  output logic        ch1_error_o,
  output logic [31:0] ch1_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic        mem_error_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY0,
    BUSY1,
    ERR0,
`ifdef INST_MEM_ARB_LOCK_EN
    ERR1,
    LOCK1
`else
    ERR1
`endif
  } state_e;

  localparam logic [31:0] Span    = MEM_END - MEM_BASE;
  localparam logic [3:0]  MaxWait = 4'(MAX_WAIT);

  state_e     state_q, state_d;
  state_e     ret1;
  logic [3:0] wait_q, wait_d;
  logic       hit0, hit1;
  logic       arb, mask0;
  logic       win0, win1;
  logic       sel0, sel1;

  // Window check as offset-from-base so a zero base needs no special case
  assign hit0 = (ch0_addr_i - MEM_BASE) <= Span;
  assign hit1 = (ch1_addr_i - MEM_BASE) <= Span;

`ifdef INST_MEM_ARB_LOCK_EN
  assign arb   = rst_ni && ((state_q == IDLE) || (state_q == LOCK1));
  assign mask0 = (state_q == LOCK1) && ch1_lock_i;
  assign ret1  = ch1_lock_i ? LOCK1 : IDLE;
`else
  assign arb   = rst_ni && (state_q == IDLE);
  assign mask0 = 1'b0;
  assign ret1  = IDLE;
`endif

  assign win1 = arb && ch1_req_i &&
                (!ch0_req_i || mask0 || (wait_q >= MaxWait));
  assign win0 = arb && ch0_req_i && !mask0 && !win1;

  // Grant selection, next state, and memory/response routing
  always_comb begin
    state_d     = state_q;
    sel0        = 1'b0;
    sel1        = 1'b0;
    ch0_ack_o   = 1'b0;
    ch0_error_o = 1'b0;
    ch0_rdata_o = '0;
    ch1_ack_o   = 1'b0;
    ch1_error_o = 1'b0;
    ch1_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      win0: begin
        if (hit0) begin
          sel0    = 1'b1;
          state_d = mem_ack_i ? IDLE : BUSY0;
        end else begin
          state_d = ERR0;
        end
      end
      win1: begin
        if (hit1) begin
          sel1    = 1'b1;
          state_d = mem_ack_i ? ret1 : BUSY1;
        end else begin
          state_d = ERR1;
        end
      end
      (state_q == BUSY0): begin
        sel0 = 1'b1;
        if (mem_ack_i) state_d = IDLE;
      end
      (state_q == BUSY1): begin
        sel1 = 1'b1;
        if (mem_ack_i) state_d = ret1;
      end
      (state_q == ERR0): begin
        ch0_ack_o   = 1'b1;
        ch0_error_o = 1'b1;
        state_d     = IDLE;
      end
      (state_q == ERR1): begin
        ch1_ack_o   = 1'b1;
        ch1_error_o = 1'b1;
        state_d     = ret1;
      end
      default: ;
    endcase
    if (sel0) begin
      mem_req_o   = 1'b1;
      mem_addr_o  = ch0_addr_i;
      ch0_ack_o   = mem_ack_i;
      ch0_error_o = mem_ack_i && mem_error_i;
      ch0_rdata_o = mem_ack_i ? mem_rdata_i : '0;
    end
    if (sel1) begin
      mem_req_o   = 1'b1;
      mem_we_o    = ch1_we_i;
      mem_be_o    = ch1_be_i;
      mem_addr_o  = ch1_addr_i;
      mem_wdata_o = ch1_wdata_i;
      ch1_ack_o   = mem_ack_i;
      ch1_error_o = mem_ack_i && mem_error_i;
      ch1_rdata_o = mem_ack_i ? mem_rdata_i : '0;
    end
  end

  // Count ch0 completions that happened while ch1 was kept waiting
  always_comb begin
    wait_d = wait_q;
    if (mask0) begin
      wait_d = wait_q;
    end else if (!ch1_req_i || ch1_ack_o) begin
      wait_d = '0;
    end else if (ch0_ack_o && (wait_q < MaxWait)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // State and starvation counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Bench for inst_mem_arbiter: vector table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_inst_mem_arbiter;

  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] LAST = 32'h0fff;
  localparam int          MAXW = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ch0_req_i, ch0_ack_o, ch0_error_o;
  logic [31:0] ch0_addr_i, ch0_rdata_o;
  logic        ch1_req_i, ch1_we_i, ch1_ack_o, ch1_error_o;
  logic [3:0]  ch1_be_i;
  logic [31:0] ch1_addr_i, ch1_wdata_i, ch1_rdata_o;
`ifdef INST_MEM_ARB_LOCK_EN
  logic        ch1_lock_i;
`endif
  logic        mem_req_o, mem_we_o, mem_ack_i, mem_error_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int nvec = 0;
  int nbad = 0;
  logic [31:0] marr [1024];

  always #5 clk_i = ~clk_i;

  inst_mem_arbiter #(.MEM_BASE(BASE), .MEM_END(LAST), .MAX_WAIT(MAXW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ch0_req_i(ch0_req_i), .ch0_addr_i(ch0_addr_i),
    .ch0_ack_o(ch0_ack_o), .ch0_error_o(ch0_error_o),
    .ch0_rdata_o(ch0_rdata_o),
    .ch1_req_i(ch1_req_i), .ch1_we_i(ch1_we_i), .ch1_be_i(ch1_be_i),
    .ch1_addr_i(ch1_addr_i), .ch1_wdata_i(ch1_wdata_i),
`ifdef INST_MEM_ARB_LOCK_EN
    .ch1_lock_i(ch1_lock_i),
`endif
    .ch1_ack_o(ch1_ack_o), .ch1_error_o(ch1_error_o),
    .ch1_rdata_o(ch1_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i),
    .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic [31:0] c0r, c0a;
    logic [31:0] c1r, c1w, c1b, c1a, c1d;
    logic [31:0] ma, me, md;
    logic [31:0] xreq, xwe, xaddr;
    logic [31:0] x0a, x0e, x0d;
    logic [31:0] x1a, x1e, x1d;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic idle_in();
    ch0_req_i = 0; ch0_addr_i = 0;
    ch1_req_i = 0; ch1_we_i = 0; ch1_be_i = 0;
    ch1_addr_i = 0; ch1_wdata_i = 0;
`ifdef INST_MEM_ARB_LOCK_EN
    ch1_lock_i = 0;
`endif
    mem_ack_i = 0; mem_error_i = 0; mem_rdata_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_zero(input string n);
    chk({n, ".ctl"},
        32'({ch0_ack_o, ch0_error_o, ch1_ack_o, ch1_error_o,
             mem_req_o, mem_we_o, mem_be_o}), 32'h0);
    chk({n, ".data"},
        ch0_rdata_o | ch1_rdata_o | mem_addr_o | mem_wdata_o, 32'h0);
  endtask

  function automatic bit hit(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) <= longint'(LAST));
  endfunction

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(9);
    if (r == 0) return 32'h1000 + 32'($urandom_range(63)) * 4;
    if (r == 1) return $urandom | 32'h8000_0000;
    if (r == 2) return 32'h0ffc;
    return 32'($urandom_range(1023)) * 4;
  endfunction

  task automatic set_ch1(input logic we, input logic [31:0] a,
                         input logic [31:0] d);
    ch1_req_i = 1; ch1_we_i = we; ch1_be_i = 4'hf;
    ch1_addr_i = a; ch1_wdata_i = d;
  endtask

  task automatic rand_run(input int n);
    int own, nown, w, cur, mw, mleft;
    bit mbusy, d0, d1;
    logic e0a, e0e, e1a, e1e, ereq, ewe;
    logic [3:0] ebe;
    logic [31:0] a, eaddr, ewd, e0d, e1d;
    own = 0; mw = 0; mleft = 0; mbusy = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < n; i++) begin
      if (d0) ch0_req_i = 0;
      if (d1) ch1_req_i = 0;
      if (!ch0_req_i && $urandom_range(2) != 0) begin
        ch0_req_i = 1; ch0_addr_i = rnd_addr();
      end
      if (!ch1_req_i && $urandom_range(3) == 0) begin
        ch1_req_i = 1; ch1_we_i = 1'($urandom_range(1));
        ch1_be_i = 4'($urandom); ch1_addr_i = rnd_addr();
        ch1_wdata_i = $urandom;
      end
      mem_ack_i = 0; mem_error_i = 0; mem_rdata_i = 0;
      #1;
      if (mem_req_o) begin
        if (!mbusy) begin
          mbusy = 1; mleft = $urandom_range(2);
        end
        if (mleft == 0) begin
          mem_ack_i = 1;
          mem_error_i = ($urandom_range(7) == 0);
          mem_rdata_i = marr[mem_addr_o[11:2]];
        end
      end else begin
        mbusy = 0;
      end
      #2;
      e0a = 0; e0e = 0; e0d = 0; e1a = 0; e1e = 0; e1d = 0;
      ereq = 0; ewe = 0; ebe = 0; eaddr = 0; ewd = 0;
      nown = own; cur = -1;
      if (own == 0) begin
        w = -1;
        if (ch1_req_i && (!ch0_req_i || mw >= MAXW)) w = 1;
        else if (ch0_req_i) w = 0;
        if (w >= 0) begin
          a = (w == 1) ? ch1_addr_i : ch0_addr_i;
          if (hit(a)) cur = w;
          else nown = 3 + w;
        end
      end else if (own < 3) begin
        cur = own - 1;
      end else begin
        if (own == 3) begin e0a = 1; e0e = 1; end
        else begin e1a = 1; e1e = 1; end
        nown = 0;
      end
      if (cur == 0) begin
        ereq = 1; eaddr = ch0_addr_i;
        e0a = mem_ack_i; e0e = mem_error_i; e0d = mem_rdata_i;
      end
      if (cur == 1) begin
        ereq = 1; eaddr = ch1_addr_i; ewe = ch1_we_i;
        ebe = ch1_be_i; ewd = ch1_wdata_i;
        e1a = mem_ack_i; e1e = mem_error_i; e1d = mem_rdata_i;
      end
      if (cur >= 0) nown = mem_ack_i ? 0 : cur + 1;
      chk("r.mem_req", 32'(mem_req_o), 32'(ereq));
      if (ereq) begin
        chk("r.mem_addr", mem_addr_o, eaddr);
        chk("r.mem_webe", 32'({mem_we_o, mem_be_o}), 32'({ewe, ebe}));
        chk("r.mem_wdata", mem_wdata_o, ewd);
      end
      chk("r.ch0_ack", 32'(ch0_ack_o), 32'(e0a));
      chk("r.ch1_ack", 32'(ch1_ack_o), 32'(e1a));
      if (e0a) begin
        chk("r.ch0_err", 32'(ch0_error_o), 32'(e0e));
        chk("r.ch0_rdata", ch0_rdata_o, e0d);
      end
      if (e1a) begin
        chk("r.ch1_err", 32'(ch1_error_o), 32'(e1e));
        chk("r.ch1_rdata", ch1_rdata_o, e1d);
      end
      if (mem_ack_i) begin
        mbusy = 0;
        if (mem_we_o)
          for (int b = 0; b < 4; b++)
            if (mem_be_o[b])
              marr[mem_addr_o[11:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
      end else if (mbusy) begin
        mleft--;
      end
      if (!ch1_req_i || e1a) mw = 0;
      else if (e0a && mw < MAXW) mw++;
      own = nown;
      d0 = ch0_ack_o; d1 = ch1_ack_o;
      tick();
    end
  endtask

  vec_t vt[7];

  initial begin
    for (int i = 0; i < 1024; i++) marr[i] = 32'hC0DE_0000 + 32'(i);
    vt[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
              0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{1, 'h100, 0, 0, 0, 0, 0, 1, 0, 'hDEADBEEF,
              1, 0, 'h100, 1, 0, 'hDEADBEEF, 0, 0, 0};
    vt[2] = '{0, 0, 1, 1, 15, 'h20, 'h12345678, 1, 0, 0,
              1, 1, 'h20, 0, 0, 0, 1, 0, 0};
    vt[3] = '{1, 'h200, 1, 0, 3, 'h40, 0, 1, 0, 'h11111111,
              1, 0, 'h200, 1, 0, 'h11111111, 0, 0, 0};
    vt[4] = '{0, 0, 1, 0, 0, 'hffc, 0, 1, 1, 'hA5A5A5A5,
              1, 0, 'hffc, 0, 0, 0, 1, 1, 'hA5A5A5A5};
    vt[5] = '{1, 'hffc, 0, 0, 0, 0, 0, 1, 0, 'h0BADF00D,
              1, 0, 'hffc, 1, 0, 'h0BADF00D, 0, 0, 0};
    vt[6] = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 'h55,
              1, 0, 0, 1, 1, 'h55, 0, 0, 0};

    idle_in();
    ch0_req_i = 1; ch0_addr_i = 32'h100;
    mem_ack_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
    #3;
    chk_zero("reset");
    tick();
    idle_in();
    tick();
    rst_ni = 1;
    #1;
    chk_zero("post_reset");

    for (int i = 0; i < 7; i++) begin
      ch0_req_i = vt[i].c0r[0]; ch0_addr_i = vt[i].c0a;
      ch1_req_i = vt[i].c1r[0]; ch1_we_i = vt[i].c1w[0];
      ch1_be_i = vt[i].c1b[3:0]; ch1_addr_i = vt[i].c1a;
      ch1_wdata_i = vt[i].c1d;
      mem_ack_i = vt[i].ma[0]; mem_error_i = vt[i].me[0];
      mem_rdata_i = vt[i].md;
      #3;
      chk($sformatf("v%0d.mem_req", i), 32'(mem_req_o), vt[i].xreq);
      chk($sformatf("v%0d.mem_we", i), 32'(mem_we_o), vt[i].xwe);
      chk($sformatf("v%0d.mem_addr", i), mem_addr_o, vt[i].xaddr);
      chk($sformatf("v%0d.mem_be", i), 32'(mem_be_o),
          vt[i].x1a[0] ? vt[i].c1b : 32'h0);
      chk($sformatf("v%0d.mem_wdata", i), mem_wdata_o,
          vt[i].x1a[0] ? vt[i].c1d : 32'h0);
      chk($sformatf("v%0d.ch0", i), 32'({ch0_ack_o, ch0_error_o}),
          {vt[i].x0a[30:0], vt[i].x0e[0]});
      chk($sformatf("v%0d.ch0_rdata", i), ch0_rdata_o, vt[i].x0d);
      chk($sformatf("v%0d.ch1", i), 32'({ch1_ack_o, ch1_error_o}),
          {vt[i].x1a[30:0], vt[i].x1e[0]});
      chk($sformatf("v%0d.ch1_rdata", i), ch1_rdata_o, vt[i].x1d);
      tick();
    end
    idle_in();
    tick();

    for (int k = 0; k < 4; k++) begin
      set_ch1(1, 32'h20, 32'h12345678);
      if (k >= 1) begin ch0_req_i = 1; ch0_addr_i = 32'h300; end
      mem_ack_i = (k == 3);
      #3;
      chk("mw.mem_req", 32'(mem_req_o), 32'h1);
      chk("mw.fields", mem_addr_o ^ mem_wdata_o, 32'h20 ^ 32'h12345678);
      chk("mw.webe", 32'({mem_we_o, mem_be_o}), 32'h1f);
      chk("mw.ch1_ack", 32'(ch1_ack_o), 32'(k == 3));
      chk("mw.ch0_ack", 32'(ch0_ack_o), 32'h0);
      tick();
    end
    ch1_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h77;
    #3;
    chk("mw.ch0_next", mem_addr_o, 32'h300);
    chk("mw.ch0_ack", 32'({ch0_ack_o, mem_we_o}), 32'h2);
    chk("mw.ch0_rdata", ch0_rdata_o, 32'h77);
    tick();
    idle_in();
    tick();

    ch0_req_i = 1; ch0_addr_i = 32'h1000; mem_ack_i = 1;
    #3;
    chk("oor.c0", 32'({mem_req_o, ch0_ack_o}), 32'h0);
    tick();
    #2;
    chk("oor.c1", 32'({mem_req_o, ch0_ack_o, ch0_error_o}), 32'h3);
    chk("oor.rdata", ch0_rdata_o, 32'h0);
    tick();
    idle_in();
    tick();

    ch0_req_i = 1; ch0_addr_i = 32'h400;
    ch1_req_i = 1; ch1_addr_i = 32'h800;
    mem_ack_i = 1; mem_rdata_i = 32'h99;
    for (int i = 0; i < 15; i++) begin
      #3;
      chk($sformatf("starve%0d", i), 32'({ch0_ack_o, ch1_ack_o}),
          (i % 5 == 4) ? 32'h1 : 32'h2);
      tick();
    end
    idle_in();
    tick();

    set_ch1(0, 32'h40, 0);
    #3;
    chk("rst.idle_req", 32'(mem_req_o), 32'h1);
    tick();
    #1;
    chk("rst.busy1_req", 32'({mem_req_o, ch1_ack_o}), 32'h2);
    rst_ni = 0;
    mem_ack_i = 1; mem_rdata_i = 32'h1234;
    #1;
    chk_zero("rst.mid");
    tick();
    idle_in();
    rst_ni = 1;
    ch0_req_i = 1; ch0_addr_i = 32'h100;
    mem_ack_i = 1; mem_rdata_i = 32'hCAFEF00D;
    #3;
    chk("rst.after_ack", 32'({ch0_ack_o, ch0_error_o}), 32'h2);
    chk("rst.after_rdata", ch0_rdata_o, 32'hCAFEF00D);
    tick();
    idle_in();
    tick();

`ifdef INST_MEM_ARB_LOCK_EN
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        set_ch1(1, 32'h80 + 32'(k) * 4, 32'(k));
        ch1_lock_i = 1;
      end else begin
        ch1_req_i = 0; ch1_lock_i = 0;
      end
      if (k >= 1) begin ch0_req_i = 1; ch0_addr_i = 32'h100; end
      mem_ack_i = 1;
      #3;
      chk($sformatf("lock%0d", k), 32'({ch0_ack_o, ch1_ack_o}),
          (k == 3) ? 32'h2 : 32'h1);
      tick();
    end
    idle_in();
    tick();
`endif

    rand_run(3000);
    idle_in();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
